// File: rtl/conv1_stream_core.sv
// Streaming KXxKY valid convolution (CI=1, CO channels) with bias and activation.
// Activation: ReLU when CONV1_RELU_EN is defined, signed saturation to O_F_BW otherwise.
`default_nettype none

module conv1_stream_core #(
    parameter int unsigned I_F_BW = 8,
    parameter int unsigned W_BW   = 8,
    parameter int unsigned B_BW   = 16,
    parameter int unsigned KX     = 5,
    parameter int unsigned KY     = 5,
    parameter int unsigned CI     = 1,
    parameter int unsigned CO     = 3,
    parameter int unsigned IX     = 28,
    parameter int unsigned IY     = 28,
    parameter int unsigned AK_BW  = 21,
    parameter int unsigned AB_BW  = 21,
    parameter int unsigned O_F_BW = 20
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [CO*CI*KX*KY*W_BW-1:0]     i_cnn_weight,
    input  logic [CO*B_BW-1:0]              i_cnn_bias,
    input  logic                            i_in_valid,
    input  logic [I_F_BW-1:0]               i_in_fmap,
    output logic                            o_ot_valid,
    output logic [CO*O_F_BW-1:0]            o_ot_fmap
);

    localparam int unsigned CX_BW = $clog2(IX);
    localparam int unsigned CY_BW = $clog2(IY);
    localparam int unsigned P_BW  = I_F_BW + 1 + W_BW;
    localparam int unsigned NTAP  = KX * KY;
`ifdef CONV1_RELU_EN
    localparam int unsigned AR_BW = 20;
`endif

    logic [CX_BW-1:0]          col_q, col_d;
    logic [CY_BW-1:0]          row_q, row_d;
    logic                      win_done_c;
    logic                      v1_q, v2_q, v3_q;

    logic [I_F_BW-1:0]         lb_q   [KY-1][IX];
    logic [I_F_BW-1:0]         colv_c [KY];
    logic [I_F_BW-1:0]         win_q  [KY][KX];
    logic signed [P_BW-1:0]    prod_q [CO][NTAP];
    logic signed [AK_BW-1:0]   acc_c  [CO];
    logic signed [AK_BW-1:0]   sum_q  [CO];
    logic [CO*O_F_BW-1:0]      fmap_c;

    // Raster position of the pixel currently on the input
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (i_in_valid) begin
            if (col_q == CX_BW'(IX - 1)) begin
                col_d = '0;
                row_d = (row_q == CY_BW'(IY - 1)) ? '0 : row_q + CY_BW'(1);
            end else begin
                col_d = col_q + CX_BW'(1);
            end
        end
    end

    assign win_done_c = i_in_valid && (col_q >= CX_BW'(KX - 1)) && (row_q >= CY_BW'(KY - 1));

    // Column entering the window: oldest buffered row at index 0, live pixel last
    always_comb begin
        for (int unsigned r = 0; r < KY - 1; r++) begin
            colv_c[r] = lb_q[KY - 2 - r][col_q];
        end
        colv_c[KY-1] = i_in_fmap;
    end

    // Line buffers shift vertically per column; lb_q[0] holds the previous row
    always_ff @(posedge clk) begin
        if (i_in_valid) begin
            lb_q[0][col_q] <= i_in_fmap;
            for (int unsigned r = 1; r < KY - 1; r++) begin
                lb_q[r][col_q] <= lb_q[r-1][col_q];
            end
        end
    end

    // Window shifts left by one column per accepted pixel
    always_ff @(posedge clk) begin
        if (i_in_valid) begin
            for (int unsigned ky = 0; ky < KY; ky++) begin
                for (int unsigned kx = 0; kx < KX - 1; kx++) begin
                    win_q[ky][kx] <= win_q[ky][kx+1];
                end
                win_q[ky][KX-1] <= colv_c[ky];
            end
        end
    end

    // Per-tap products: unsigned pixel times signed weight
    always_ff @(posedge clk) begin
        if (v1_q) begin
            for (int unsigned co = 0; co < CO; co++) begin
                for (int unsigned ky = 0; ky < KY; ky++) begin
                    for (int unsigned kx = 0; kx < KX; kx++) begin
                        prod_q[co][ky*KX+kx] <=
                            P_BW'($signed({1'b0, win_q[ky][kx]})) *
                            P_BW'($signed(i_cnn_weight[((co*KY+ky)*KX+kx)*W_BW +: W_BW]));
                    end
                end
            end
        end
    end

    always_comb begin
        for (int unsigned co = 0; co < CO; co++) begin
            acc_c[co] = '0;
            for (int unsigned t = 0; t < NTAP; t++) begin
                acc_c[co] = acc_c[co] + AK_BW'(prod_q[co][t]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (v2_q) begin
            for (int unsigned co = 0; co < CO; co++) begin
                sum_q[co] <= acc_c[co];
            end
        end
    end

    function automatic logic [O_F_BW-1:0] act_f(input logic signed [AB_BW-1:0] ab);
`ifdef CONV1_RELU_EN
        logic [AR_BW-1:0] r;
        r = ab[AB_BW-1] ? '0 : ab[AR_BW-1:0];
        return O_F_BW'(r);
`else
        logic [AB_BW-O_F_BW:0] hi;
        hi = ab[AB_BW-1:O_F_BW-1];
        if ((&hi) || (~|hi)) begin
            return ab[O_F_BW-1:0];
        end
        return ab[AB_BW-1] ? {1'b1, {(O_F_BW-1){1'b0}}} : {1'b0, {(O_F_BW-1){1'b1}}};
`endif
    endfunction

    always_comb begin
        logic signed [AB_BW-1:0] ab;
        ab     = '0;
        fmap_c = '0;
        for (int unsigned co = 0; co < CO; co++) begin
            ab = AB_BW'(sum_q[co]) + AB_BW'($signed(i_cnn_bias[co*B_BW +: B_BW]));
            fmap_c[co*O_F_BW +: O_F_BW] = act_f(ab);
        end
    end

    // Control registers; output word holds between results
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q      <= '0;
            row_q      <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            v3_q       <= 1'b0;
            o_ot_valid <= 1'b0;
            o_ot_fmap  <= '0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            v1_q       <= win_done_c;
            v2_q       <= v1_q;
            v3_q       <= v2_q;
            o_ot_valid <= v3_q;
            if (v3_q) begin
                o_ot_fmap <= fmap_c;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_conv1_stream_core.sv
// Scoreboard bench for conv1_stream_core: the driver queues expected words and
// due cycles, a forked monitor pops and compares each o_ot_valid result.
`timescale 1ns/1ps

module tb_conv1_stream_core;

    localparam int IX = 28, IY = 28, KX = 5, KY = 5, CO = 3, OW = 20;

`ifdef CONV1_RELU_EN
    localparam logic [OW-1:0] T1_CH1  = 20'd0;
    localparam logic [OW-1:0] MAX_POS = 20'd842392;
    localparam logic [OW-1:0] MAX_NEG = 20'd0;
`else
    localparam logic [OW-1:0] T1_CH1  = 20'hFFFF1;
    localparam logic [OW-1:0] MAX_POS = 20'h7FFFF;
    localparam logic [OW-1:0] MAX_NEG = 20'h80000;
`endif

    logic               clk = 1'b0;
    logic               reset_n;
    logic [599:0]       w;
    logic [47:0]        b;
    logic               in_valid;
    logic [7:0]         in_fmap;
    logic               ot_valid;
    logic [CO*OW-1:0]   ot_fmap;

    int unsigned cyc = 0;
    int errors = 0;
    int checks = 0;
    int mode   = 0;

    logic [CO*OW-1:0] exp_q[$];
    int unsigned      stamp_q[$];

    int img [2][IY][IX];
    int wt  [CO][KY][KX];
    int bs  [CO];

    conv1_stream_core dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_cnn_weight (w),
        .i_cnn_bias   (b),
        .i_in_valid   (in_valid),
        .i_in_fmap    (in_fmap),
        .o_ot_valid   (ot_valid),
        .o_ot_fmap    (ot_fmap)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish, required finish before 2ms");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic logic [OW-1:0] act_f(input longint v);
`ifdef CONV1_RELU_EN
        if (v < 0) return '0;
        return OW'(v);
`else
        if (v > 524287)  return 20'h7FFFF;
        if (v < -524288) return 20'h80000;
        return OW'(v);
`endif
    endfunction

    function automatic logic [CO*OW-1:0] model(input int f, input int ox, input int oy);
        logic [CO*OW-1:0] r;
        longint s;
        r = '0;
        for (int co = 0; co < CO; co++) begin
            s = bs[co];
            for (int ky = 0; ky < KY; ky++)
                for (int kx = 0; kx < KX; kx++)
                    s += longint'(img[f][oy+ky][ox+kx]) * longint'(wt[co][ky][kx]);
            r[co*OW +: OW] = act_f(s);
        end
        return r;
    endfunction

    function automatic logic [CO*OW-1:0] expected(input int f, input int ox, input int oy);
        case (mode)
            1:       return {20'd7, T1_CH1, 20'd25};
            2:       return {20'd0, 20'd0, 20'(ox + 2)};
            3:       return {MAX_POS, MAX_POS, MAX_POS};
            4:       return {MAX_NEG, MAX_NEG, MAX_NEG};
            default: return model(f, ox, oy);
        endcase
    endfunction

    task automatic pack_params();
        for (int co = 0; co < CO; co++) begin
            b[co*16 +: 16] = 16'(bs[co]);
            for (int ky = 0; ky < KY; ky++)
                for (int kx = 0; kx < KX; kx++)
                    w[((co*KY+ky)*KX+kx)*8 +: 8] = 8'(wt[co][ky][kx]);
        end
    endtask

    task automatic set_weights(input int val);
        for (int co = 0; co < CO; co++) begin
            bs[co] = 0;
            for (int ky = 0; ky < KY; ky++)
                for (int kx = 0; kx < KX; kx++) wt[co][ky][kx] = val;
        end
    endtask

    task automatic fill_img(input int f, input int kind);
        for (int y = 0; y < IY; y++)
            for (int x = 0; x < IX; x++)
                case (kind)
                    0:       img[f][y][x] = 1;
                    1:       img[f][y][x] = x;
                    2:       img[f][y][x] = 255;
                    default: img[f][y][x] = int'($urandom_range(0, 255));
                endcase
    endtask

    // Pixel in the negedge before accepting edge k; result visible at the negedge with cyc=k+3
    task automatic drive_frame(input int f, input int gap_max, input int stop_row);
        for (int y = 0; y < IY; y++) begin
            if (y == stop_row) return;
            for (int x = 0; x < IX; x++) begin
                repeat (int'($urandom_range(0, gap_max))) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                end
                @(negedge clk);
                in_valid = 1'b1;
                in_fmap  = 8'(img[f][y][x]);
                if (x >= KX - 1 && y >= KY - 1) begin
                    exp_q.push_back(expected(f, x - KX + 1, y - KY + 1));
                    stamp_q.push_back(cyc + 4);
                end
            end
        end
    endtask

    task automatic drain(input string name);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        chk({name, "_pending"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        stamp_q.delete();
    endtask

    task automatic monitor();
        logic [CO*OW-1:0] e;
        int unsigned      s;
        forever begin
            @(negedge clk);
            if (reset_n && ot_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got fmap %h at cyc %0d, required no result", ot_fmap, cyc);
                end else begin
                    e = exp_q.pop_front();
                    s = stamp_q.pop_front();
                    chk("result_fmap", 64'(ot_fmap), 64'(e));
                    chk("result_cycle", 64'(cyc), 64'(s));
                end
            end
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_fmap  = '0;
        w        = '0;
        b        = '0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        chk("reset_valid", 64'(ot_valid), 64'd0);
        chk("reset_fmap", 64'(ot_fmap), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Ones image: {25, -15 or 0, 7}
        fill_img(0, 0);
        set_weights(0);
        for (int ky = 0; ky < KY; ky++)
            for (int kx = 0; kx < KX; kx++) begin
                wt[0][ky][kx] = 1;
                wt[1][ky][kx] = -1;
            end
        wt[2][2][2] = 2;
        bs[1] = 10;
        bs[2] = 5;
        pack_params();
        mode = 1;
        drive_frame(0, 0, IY);
        drain("ones");

        // Horizontal ramp, centre tap only: ch0 = ox+2
        fill_img(0, 1);
        set_weights(0);
        wt[0][2][2] = 1;
        pack_params();
        mode = 2;
        drive_frame(0, 0, IY);
        drain("ramp");

        // Extremes
        fill_img(0, 2);
        set_weights(127);
        for (int co = 0; co < CO; co++) bs[co] = 32767;
        pack_params();
        mode = 3;
        drive_frame(0, 0, IY);
        drain("max_pos");

        set_weights(-128);
        for (int co = 0; co < CO; co++) bs[co] = 32767;
        pack_params();
        mode = 4;
        drive_frame(0, 0, IY);
        drain("max_neg");

        // Random image and parameters: continuous, then with input gaps
        fill_img(0, 3);
        fill_img(1, 3);
        for (int co = 0; co < CO; co++) begin
            bs[co] = int'($urandom_range(0, 65535)) - 32768;
            for (int ky = 0; ky < KY; ky++)
                for (int kx = 0; kx < KX; kx++)
                    wt[co][ky][kx] = int'($urandom_range(0, 255)) - 128;
        end
        pack_params();
        mode = 0;
        drive_frame(0, 0, IY);
        drain("rand_cont");
        drive_frame(0, 5, IY);
        drain("rand_gaps");

        // Reset in row 10, then a fresh frame
        drive_frame(0, 0, 10);
        @(negedge clk);
        reset_n = 1'b0;
        exp_q.delete();
        stamp_q.delete();
        repeat (3) @(negedge clk);
        chk("midreset_valid", 64'(ot_valid), 64'd0);
        chk("midreset_fmap", 64'(ot_fmap), 64'd0);
        in_valid = 1'b0;
        reset_n  = 1'b1;
        @(negedge clk);
        drive_frame(1, 0, IY);
        drain("after_reset");

        // Two frames back to back
        drive_frame(0, 0, IY);
        drive_frame(1, 0, IY);
        drain("b2b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
